// File: rtl/shiftn_pkg.sv
// Shared constants and helpers for the shiftn serial transmitter/receiver family.
package shiftn_pkg;

  localparam int N_DEFAULT = 8;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Received-bit counter: counts 0..n-1, restarts on Sync, flags the last bit of a word.
module bit_counter
  import shiftn_pkg::*;
#(
  parameter int n  = N_DEFAULT,
  parameter int CW = clog2(n)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(n - 1));

  // A Sync edge that also samples a bit makes that bit number 0, so the count lands on 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (sync) begin
      count <= en ? CW'(1) : '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/shiftn_rx.sv
// LSB-first serial-to-parallel receiver with a Valid/Ack holding register and sticky overrun.
module shiftn_rx
  import shiftn_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         w,
  input  logic         En,
  input  logic         Sync,
  input  logic         Ack,
  output logic [n-1:0] Q,
  output logic         Valid,
  output logic         Overrun,
  output logic         Busy
);

  localparam int CW = clog2(n);

  logic [n-1:0]  sr;
  logic [CW-1:0] count;
  logic          last;
  logic          complete;

  bit_counter #(.n(n), .CW(CW)) u_bit_counter (
    .clk   (Clock),
    .rst_n (Resetn),
    .en    (En),
    .sync  (Sync),
    .count (count),
    .last  (last)
  );

  assign complete = En && !Sync && last;
  assign Busy     = (count != '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sr      <= '0;
      Q       <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (Sync) begin
        sr <= En ? {w, {(n-1){1'b0}}} : '0;
      end else if (En) begin
        sr <= {w, sr[n-1:1]};
      end

      if (complete) begin
        Q     <= {w, sr[n-1:1]};
        Valid <= 1'b1;
      end else if (Ack) begin
        Valid <= 1'b0;
      end

      // Newest word always wins; overrun only records that an unconsumed word was lost.
      if (Ack) begin
        Overrun <= 1'b0;
      end else if (complete && Valid) begin
        Overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shiftn_rx.sv
// Bench for shiftn_rx: directed vector table, async reset sequence, randomized model check.
module tb_shiftn_rx;

  localparam int N = 8;

  logic         Clock;
  logic         Resetn;
  logic         w;
  logic         En;
  logic         Sync;
  logic         Ack;
  logic [N-1:0] Q;
  logic         Valid;
  logic         Overrun;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  shiftn_rx #(.n(N)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .w       (w),
    .En      (En),
    .Sync    (Sync),
    .Ack     (Ack),
    .Q       (Q),
    .Valid   (Valid),
    .Overrun (Overrun),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       en;
    logic       sync;
    logic       ack;
    logic       w;
    logic [7:0] q;
    logic       v;
    logic       o;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic sync, input logic ack, input logic wb,
                              input logic [7:0] q, input logic v, input logic o, input logic b);
    vec_t e;
    e.en = en; e.sync = sync; e.ack = ack; e.w = wb;
    e.q = q; e.v = v; e.o = o; e.b = b;
    vecs.push_back(e);
  endfunction

  // One word LSB-first; outputs hold their previous values until the last bit lands.
  function automatic void add_word(input logic [7:0] val, input logic ack_last,
                                   input logic [7:0] q_prev, input logic v_prev,
                                   input logic o_prev, input logic o_after, input logic gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        add(1'b1, 1'b0, ack_last, val[i], val, 1'b1, o_after, 1'b0);
        if (gap) add(1'b0, 1'b0, 1'b0, ~val[i], val, 1'b1, o_after, 1'b0);
      end else begin
        add(1'b1, 1'b0, 1'b0, val[i], q_prev, v_prev, o_prev, 1'b1);
        if (gap) add(1'b0, 1'b0, 1'b0, ~val[i], q_prev, v_prev, o_prev, 1'b1);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic sync, input logic ack, input logic wb);
    En = en; Sync = sync; Ack = ack; w = wb;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] q, input logic v,
                         input logic o, input logic b);
    chk({tag, ".Q"},       32'(Q),       32'(q));
    chk({tag, ".Valid"},   32'(Valid),   32'(v));
    chk({tag, ".Overrun"}, 32'(Overrun), 32'(o));
    chk({tag, ".Busy"},    32'(Busy),    32'(b));
  endtask

  // Reference model state: bits of the word in progress, and the presented word.
  logic bits[$];
  logic [7:0] m_q;
  logic m_v, m_o;

  initial begin
    logic [7:0] s3c;
    logic [7:0] word;
    logic ren, rsync, rack, rw, done;

    Clock = 1'b0; Resetn = 1'b0;
    En = 1'b0; Sync = 1'b0; Ack = 1'b0; w = 1'b0;

    // Directed table
    add_word(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    add_word(8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    s3c = 8'h3C;
    add(1'b1, 1'b1, 1'b0, s3c[0], 8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 7; i++) add(1'b1, 1'b0, 1'b0, s3c[i], 8'hA5, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, s3c[7], 8'h3C, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    add_word(8'h11, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'h22, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    add_word(8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'h7E, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge Clock);
    #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].sync, vecs[i].ack, vecs[i].w);
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].v, vecs[i].o, vecs[i].b);
    end

    // Async reset mid-word with a valid word pending
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("pre_rst", 8'h7E, 1'b1, 1'b0, 1'b1);
    end
    #2 Resetn = 1'b0;
    #1 chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    #2 Resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 7) chk_all("ff_last", 8'hFF, 1'b1, 1'b0, 1'b0);
      else        chk_all("ff_bit", 8'h00, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("ff_ack", 8'hFF, 1'b0, 1'b0, 1'b0);

    // Randomized stream against the word-level model
    bits.delete();
    m_q = 8'hFF; m_v = 1'b0; m_o = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ren   = ($urandom_range(0, 99) < 70);
      rsync = ($urandom_range(0, 99) < 5);
      rack  = ($urandom_range(0, 99) < 15);
      rw    = 1'($urandom_range(0, 1));
      done  = 1'b0;
      word  = '0;
      if (rsync) bits.delete();
      if (ren) bits.push_back(rw);
      if (bits.size() == N) begin
        for (int k = 0; k < N; k++) word = word | (8'(bits[k]) << k);
        bits.delete();
        done = 1'b1;
      end
      if (done) begin
        m_o = rack ? 1'b0 : (m_v ? 1'b1 : m_o);
        m_v = 1'b1;
        m_q = word;
      end else if (rack) begin
        m_v = 1'b0;
        m_o = 1'b0;
      end
      drive(ren, rsync, rack, rw);
      chk_all($sformatf("rnd%0d", c), m_q, m_v, m_o, bits.size() != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
